// File: rtl/instr_encoder.sv
// RV32I field-set encoder with an output FIFO.
// Each legal field set becomes one word bound to a running address.
module instr_encoder #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   addr_mem_q  [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [31:0]   addr_q;
  logic          err_q;
  logic [7:0]    err_cnt_q;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          accept;
  logic          push;
  logic          reject;
  logic          pop;

  // Pack the fields for the selected format and judge immediate range.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    unique case (fmt)
      3'd0: begin
        enc_word  = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_legal = 1'b1;
      end
      3'd1: begin
        enc_word  = {imm[11:0], rs1, funct3, rd, opcode};
        enc_legal = (&imm[31:11]) | ~(|imm[31:11]);
      end
      3'd2: begin
        enc_word  = {imm[11:5], rs2, rs1, funct3,
                     imm[4:0], opcode};
        enc_legal = (&imm[31:11]) | ~(|imm[31:11]);
      end
      3'd3: begin
        enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3,
                     imm[4:1], imm[11], opcode};
        enc_legal = ((&imm[31:12]) | ~(|imm[31:12]))
                  & ~imm[0];
      end
      3'd4: begin
        enc_word  = {imm[31:12], rd, opcode};
        enc_legal = ~(|imm[11:0]);
      end
      3'd5: begin
        enc_word  = {imm[20], imm[10:1], imm[11],
                     imm[19:12], rd, opcode};
        enc_legal = ((&imm[31:20]) | ~(|imm[31:20]))
                  & ~imm[0];
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_legal;
  assign reject    = accept & ~enc_legal;
  assign pop       = out_valid & out_ready;

  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q]  : '0;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  // Occupancy: push and pop in one cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; stale slots are hidden by the pointers after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= enc_word;
      addr_mem_q[wr_ptr_q]  <= addr_q;
    end
  end

  // Pointers, address counter and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        addr_q   <= addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (reject) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule
